// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared core types for the MEM-stage load/store unit
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // MEM-stage request as presented by the pipeline
    typedef struct packed {
        logic        op_valid;
        logic        op_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    // Width code must exist for the direction, and halves/words must be naturally aligned
    function automatic logic access_legal(input logic store, input logic [2:0] f3, input logic [1:0] lo);
        logic width_ok;
        logic align_ok;
        if (store) width_ok = (f3 inside {F3_B, F3_H, F3_W});
        else       width_ok = (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (f3)
            F3_H, F3_HU: align_ok = (lo[0] == 1'b0);
            F3_W:        align_ok = (lo == 2'b00);
            default:     align_ok = 1'b1;
        endcase
        return width_ok && align_ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - data memory request/response bus
interface dmem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_lsu_store_align.sv
// rtl/dmem_lsu_store_align.sv - byte-lane strobe and data replication for stores
module store_align
    import dmem_lsu_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane
);

    // Loads carry no strobes; stores replicate the source across lanes so any lane pick works
    always_comb begin
        wstrb      = 4'b0000;
        wdata_lane = 32'h0;
        if (store) begin
            case (funct3)
                F3_B: begin
                    wstrb      = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                F3_H: begin
                    wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_lane = {2{wdata[15:0]}};
                end
                F3_W: begin
                    wstrb      = 4'b1111;
                    wdata_lane = wdata;
                end
                default: begin
                    wstrb      = 4'b0000;
                    wdata_lane = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - MEM-stage load/store unit with bus timeout
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    dmem_lsu_if.master  bus,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    mem_op_t     op;
    lsu_state_t  state;
    logic [7:0]  cnt;
    logic [1:0]  byte_off;
    logic        legal;
    logic        accept;
    logic        timeout;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt;

    assign op = '{op_valid, op_store, funct3, addr, wdata};

    assign legal      = access_legal(op.op_store, op.funct3, op.addr[1:0]);
    assign accept     = (state == IDLE) && op.op_valid && legal;
    assign misaligned = (state == IDLE) && op.op_valid && !legal;
    assign stall      = (state == REQ) || (state == WAIT) || accept;

    // Abort only when the bus has made no progress in the last allowed cycle
    assign timeout = (((state == REQ) && !bus.gnt) || ((state == WAIT) && !bus.rvalid))
                     && ((cnt + 8'd1) == TIMEOUT_LIM);
    assign bus_err = timeout;

    store_align u_store_align (
        .store      (op.op_store),
        .funct3     (op.funct3),
        .addr_lo    (op.addr[1:0]),
        .wdata      (op.wdata),
        .wstrb      (strb_fmt),
        .wdata_lane (wdata_fmt)
    );

    // Access sequencer: accept, hold request until grant, await read data, one-cycle completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            byte_off  <= 2'b00;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= 32'h0;
            bus.wstrb <= 4'b0000;
            bus.wdata <= 32'h0;
            done      <= 1'b0;
            ld_data   <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        cnt       <= 8'd0;
                        byte_off  <= op.addr[1:0];
                        bus.req   <= 1'b1;
                        bus.we    <= op.op_store;
                        bus.addr  <= {op.addr[31:2], 2'b00};
                        bus.wstrb <= strb_fmt;
                        bus.wdata <= wdata_fmt;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bus.req <= 1'b0;
                        ld_data <= 32'h0;
                    end else if (bus.gnt) begin
                        bus.req <= 1'b0;
                        if (bus.we) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        ld_data <= 32'h0;
                    end else if (bus.rvalid) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        ld_data <= bus.rdata >> {byte_off, 3'b000};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    dmem_lsu_if bus ();

    dmem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .bus        (bus),
        .stall      (stall),
        .done       (done),
        .ld_data    (ld_data),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, input logic [3:0] es, input logic [31:0] ew);
        next_cycle();
        op_valid = 1'b1; op_store = 1'b1; funct3 = f3; addr = a; wdata = wd;
        #1;
        check({tag, "_acc_stall"}, stall, 1);
        check({tag, "_acc_req"}, bus.req, 0);
        next_cycle();
        op_valid = 1'b0; bus.gnt = 1'b1;
        #1;
        check({tag, "_req"}, bus.req, 1);
        check({tag, "_we"}, bus.we, 1);
        check({tag, "_addr"}, bus.addr, {a[31:2], 2'b00});
        check({tag, "_wstrb"}, bus.wstrb, es);
        check({tag, "_wdata"}, bus.wdata, ew);
        check({tag, "_req_stall"}, stall, 1);
        next_cycle();
        bus.gnt = 1'b0;
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_done_stall"}, stall, 0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rd, input logic [31:0] exp);
        next_cycle();
        op_valid = 1'b1; op_store = 1'b0; funct3 = f3; addr = a;
        #1;
        check({tag, "_acc_stall"}, stall, 1);
        next_cycle();
        op_valid = 1'b0; bus.gnt = 1'b1;
        #1;
        check({tag, "_req"}, bus.req, 1);
        check({tag, "_we"}, bus.we, 0);
        check({tag, "_addr"}, bus.addr, {a[31:2], 2'b00});
        next_cycle();
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = rd;
        #1;
        check({tag, "_wait_stall"}, stall, 1);
        next_cycle();
        bus.rvalid = 1'b0; bus.rdata = 32'h0;
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_ld"}, ld_data, exp);
        check({tag, "_done_stall"}, stall, 0);
    endtask

    task automatic check_illegal(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
        next_cycle();
        op_valid = 1'b1; op_store = st; funct3 = f3; addr = a; wdata = 32'h5555AAAA;
        #1;
        check({tag, "_mis"}, misaligned, 1);
        check({tag, "_stall"}, stall, 0);
        next_cycle();
        op_valid = 1'b0;
        #1;
        check({tag, "_mis_clr"}, misaligned, 0);
        check({tag, "_no_req"}, bus.req, 0);
        check({tag, "_stall_clr"}, stall, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0; op_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;

        // reset state
        next_cycle();
        next_cycle();
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_req", bus.req, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_ld", ld_data, 0);
        check("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        next_cycle();
        #1;
        check("post_rst_done", done, 0);

        // sb at byte 3 replicates the byte and strobes lane 3
        do_store("sb", 32'h0000_1003, 3'b000, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        next_cycle();
        #1;
        check("sb_done_clr", done, 0);

        do_store("sh", 32'h0000_4006, 3'b001, 32'h1234_5678, 4'b1100, 32'h5678_5678);
        do_store("sw", 32'h0000_5000, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // lhu at 0x2002: same-cycle gnt+rvalid counts as grant only, data arrives two cycles later
        next_cycle();
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'b101; addr = 32'h0000_2002;
        #1;
        check("lhu_acc_stall", stall, 1);
        next_cycle();
        op_valid = 1'b0; bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_DEAD;
        #1;
        check("lhu_req", bus.req, 1);
        check("lhu_addr", bus.addr, 32'h0000_2000);
        next_cycle();
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        #1;
        check("lhu_wait1_stall", stall, 1);
        check("lhu_wait1_done", done, 0);
        check("lhu_wait1_req", bus.req, 0);
        next_cycle();
        bus.rvalid = 1'b1; bus.rdata = 32'hBEEF_1234;
        #1;
        check("lhu_wait2_stall", stall, 1);
        next_cycle();
        bus.rvalid = 1'b0; bus.rdata = 32'h0;
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
        #1;
        check("lhu_done", done, 1);
        check("lhu_ld", ld_data, 32'h0000_BEEF);
        check("lhu_done_ignores_op", stall, 0);
        next_cycle();
        op_valid = 1'b0;
        #1;
        check("lhu_after_no_req", bus.req, 0);
        check("lhu_ld_held", ld_data, 32'h0000_BEEF);
        check("lhu_done_clr", done, 0);

        do_load("lb", 32'h0000_0101, 3'b000, 32'h1122_3344, 32'h0011_2233);
        do_load("lw", 32'h0000_0200, 3'b010, 32'h8765_4321, 32'h8765_4321);
        do_load("lbu3", 32'h0000_0303, 3'b100, 32'hA1B2_C3D4, 32'h0000_00A1);

        check_illegal("lw_mis", 1'b0, 3'b010, 32'h0000_3001);
        check_illegal("lh_mis", 1'b0, 3'b001, 32'h0000_3003);
        check_illegal("sh_mis", 1'b1, 3'b001, 32'h0000_3001);
        check_illegal("st_f3_100", 1'b1, 3'b100, 32'h0000_3000);
        check_illegal("ld_f3_011", 1'b0, 3'b011, 32'h0000_3000);

        // grant withheld: four REQ cycles, bus_err on the fourth, then done with ld_data cleared
        next_cycle();
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
        #1;
        check("to_acc_stall", stall, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            op_valid = 1'b0;
            #1;
            check($sformatf("to_req%0d_err", i), bus_err, 0);
            check($sformatf("to_req%0d_req", i), bus.req, 1);
        end
        next_cycle();
        #1;
        check("to_err", bus_err, 1);
        check("to_err_stall", stall, 1);
        next_cycle();
        #1;
        check("to_err_clr", bus_err, 0);
        check("to_done", done, 1);
        check("to_ld", ld_data, 0);
        check("to_req_clr", bus.req, 0);
        check("to_done_stall", stall, 0);

        // load a nonzero value, then reset mid-WAIT
        do_load("pre_rst", 32'h0000_0400, 3'b010, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        next_cycle();
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0800;
        #1;
        next_cycle();
        op_valid = 1'b0; bus.gnt = 1'b1;
        #1;
        next_cycle();
        bus.gnt = 1'b0;
        #1;
        check("wr_wait_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("wr_stall", stall, 0);
        check("wr_addr", bus.addr, 0);
        check("wr_ld", ld_data, 0);
        check("wr_done", done, 0);
        next_cycle();
        rst_n = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777;
        #1;
        check("wr_late_stall", stall, 0);
        next_cycle();
        bus.rvalid = 1'b0;
        #1;
        check("wr_late_done", done, 0);
        check("wr_late_ld", ld_data, 0);
        next_cycle();
        #1;
        check("wr_late_done2", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
